// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM BIST master: FSM states, data pattern, Wishbone constants.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } bist_state_e;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [3:0] WB_SEL_ALL     = 4'b1111;

    // Address-derived test word: complemented index in the upper half, true index in the lower.
    function automatic logic [31:0] bist_pattern(input logic [31:0] seed, input logic [15:0] idx);
        return seed ^ {~idx, idx};
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-transaction ack wait counter; expire pulses on the cycle the wait budget runs out.
module wb_ack_timer
    import sram_bist_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ack,
    output logic expire
);

    logic [15:0] count_q, count_d;

    // Count cycles spent waiting; any ack or leaving the wait state restarts from zero.
    always_comb begin
        count_d = count_q;
        if (clr || ack) begin
            count_d = '0;
        end else begin
            count_d = count_q + 16'd1;
        end
    end

    assign expire = !clr && !ack && (count_q == 16'(TIMEOUT - 1));

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_sram_bist.sv
// Wishbone classic master that writes an address pattern over a word range, reads it back and reports errors.
module wb_sram_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 22,
    parameter int unsigned BASE_WORD = 0,
    parameter int unsigned WORDS     = 1024,
    parameter logic [31:0] SEED      = 32'hA5A55A5A,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] err_addr,
    output logic [31:0] err_data,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_addr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_data_o,
    input  logic [31:0] wbm_data_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned IW = ADDR_BITS - 2;
    localparam logic [IW-1:0] FIRST_IDX = IW'(BASE_WORD);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BASE_WORD + WORDS - 1);

    bist_state_e   state_q, state_d;
    logic          start_q, start_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic [31:0]   err_data_q, err_data_d;

    logic          waiting;
    logic          timer_clr;
    logic          ack_expire;
    logic          start_edge;
    logic          accept;
    logic [31:0]   cur_addr;

    assign cur_addr  = 32'({idx_q, 2'b00});
    assign waiting   = (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);
    assign timer_clr = !waiting;

    wb_ack_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_ack_timer (
        .clk   (clk),
        .rst_n (rst),
        .clr   (timer_clr),
        .ack   (wbm_ack_i),
        .expire(ack_expire)
    );

    // Next-state and result logic; busy/done are registered from the state so they lag it by one cycle.
    always_comb begin
        state_d     = state_q;
        start_d     = start;
        idx_d       = idx_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        busy_d      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        start_edge  = start && !start_q;
        accept      = start_edge && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    done_d = 1'b1;
                    pass_d = !timeout_q && (err_count_q == '0);
                end
                if (accept) begin
                    state_d     = ST_WR_REQ;
                    idx_d       = FIRST_IDX;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    err_count_d = '0;
                    err_addr_d  = '0;
                    err_data_d  = '0;
                end
            end
            ST_WR_REQ: begin
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = FIRST_IDX;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_WR_REQ;
                    end
                end else if (ack_expire) begin
                    cyc_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    if (wbm_data_i != wdata_q) begin
                        if (err_count_q == '0) begin
                            err_addr_d = cur_addr;
                            err_data_d = wbm_data_i;
                        end
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_RD_REQ;
                    end
                end else if (ack_expire) begin
                    cyc_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wdata_d = bist_pattern(SEED, 16'(idx_d));
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign err_count  = err_count_q;
    assign err_addr   = err_addr_q;
    assign err_data   = err_data_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_addr_o = cur_addr;
    assign wbm_cti_o  = WB_CTI_CLASSIC;
    assign wbm_bte_o  = WB_BTE_LINEAR;
    assign wbm_sel_o  = WB_SEL_ALL;
    assign wbm_we_o   = we_q;
    assign wbm_data_o = wdata_q;

endmodule

// File: tb/tb_wb_sram_bist.sv
// Directed bench for wb_sram_bist with a configurable Wishbone slave model.
module tb_wb_sram_bist;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] err_addr, err_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_addr_o, wbm_data_o, wbm_data_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;

    // Slave model controls
    int unsigned waits   = 0;
    logic        noack   = 1'b0;
    logic        corrupt = 1'b0;

    // Slave model and monitor state
    logic [31:0] mem [0:7];
    logic [31:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];
    int unsigned wcnt       = 0;
    int unsigned wr_cnt     = 0;
    int unsigned rd_cnt     = 0;
    int unsigned cyc_cycles = 0;
    int unsigned stb_mis    = 0;
    int unsigned unstable   = 0;
    int unsigned idle_viol  = 0;
    logic        prev_cyc   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic        prev_we    = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Samples taken by run_once
    logic        busy_n, cyc_n, busy_n1, cyc_n1, done_n;
    logic [15:0] errc_n;
    int unsigned cycles;

    wb_sram_bist #(
        .ADDR_BITS(22),
        .BASE_WORD(0),
        .WORDS(4),
        .SEED(32'hA5A55A5A),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err_count (err_count),
        .err_addr  (err_addr),
        .err_data  (err_data),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_addr_o(wbm_addr_o),
        .wbm_cti_o (wbm_cti_o),
        .wbm_bte_o (wbm_bte_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_data_o(wbm_data_o),
        .wbm_data_i(wbm_data_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 clk = ~clk;

    assign wbm_ack_i  = wbm_cyc_o && wbm_stb_o && !noack && (wcnt == waits);
    assign wbm_data_i = mem[wbm_addr_o[4:2]] ^ ((corrupt && wbm_addr_o[4:2] == 3'd2) ? 32'h1 : 32'h0);

    // Slave memory, wait-state counter and bus protocol monitor
    always @(posedge clk) begin
        if (!wbm_cyc_o || wbm_ack_i) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
        if (wbm_cyc_o) cyc_cycles <= cyc_cycles + 1;
        if (wbm_cyc_o !== wbm_stb_o) stb_mis <= stb_mis + 1;
        if (wbm_cyc_o && prev_cyc &&
            (wbm_addr_o != prev_addr || wbm_we_o != prev_we || (wbm_we_o && wbm_data_o != prev_data)))
            unstable <= unstable + 1;
        if (wbm_cyc_o && prev_ack) idle_viol <= idle_viol + 1;
        prev_cyc  <= wbm_cyc_o;
        prev_ack  <= wbm_ack_i;
        prev_we   <= wbm_we_o;
        prev_addr <= wbm_addr_o;
        prev_data <= wbm_data_o;
        if (wbm_ack_i) begin
            if (wbm_we_o) begin
                mem[wbm_addr_o[4:2]]    <= wbm_data_o;
                wr_addr_log[wr_cnt % 64] <= wbm_addr_o;
                wr_data_log[wr_cnt % 64] <= wbm_data_o;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Raise start so that it is sampled at the next rising edge (edge N); returns just after edge N.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    // Full run: samples after edges N and N+1, then counts edges after N until done (bounded).
    task automatic run_once(input int unsigned budget);
        pulse_start();
        #1;
        busy_n = busy;
        cyc_n  = wbm_cyc_o;
        done_n = done;
        errc_n = err_count;
        @(posedge clk);
        #1;
        busy_n1 = busy;
        cyc_n1  = wbm_cyc_o;
        start   = 1'b0;
        cycles  = 1;
        while (!done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w0, r0, c0, u0, found;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_errcnt", err_count, 0);
        check_eq("rst_erraddr", err_addr, 0);
        check_eq("rst_errdata", err_data, 0);
        check_eq("rst_cyc", wbm_cyc_o, 0);
        check_eq("rst_stb", wbm_stb_o, 0);
        check_eq("rst_we", wbm_we_o, 0);
        check_eq("rst_addr", wbm_addr_o, 0);
        check_eq("rst_wdata", wbm_data_o, 0);
        check_eq("rst_cti", wbm_cti_o, 3'b000);
        check_eq("rst_bte", wbm_bte_o, 2'b00);
        check_eq("rst_sel", wbm_sel_o, 4'b1111);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait clean run
        w0 = wr_cnt; r0 = rd_cnt;
        run_once(60);
        check_eq("t1_busy_at_n", busy_n, 0);
        check_eq("t1_cyc_at_n", cyc_n, 0);
        check_eq("t1_busy_at_n1", busy_n1, 1);
        check_eq("t1_cyc_at_n1", cyc_n1, 1);
        check_eq("t1_done_cycles", cycles, 17);
        check_eq("t1_pass", pass, 1);
        check_eq("t1_errcnt", err_count, 0);
        check_eq("t1_timeout", timeout, 0);
        check_eq("t1_busy_end", busy, 0);
        check_eq("t1_writes", wr_cnt - w0, 4);
        check_eq("t1_reads", rd_cnt - r0, 4);
        for (int k = 0; k < 4; k++)
            check_eq("t1_wr_addr", wr_addr_log[(w0 + k) % 64], 32'(4 * k));
        check_eq("t1_wr_data0", wr_data_log[(w0 + 0) % 64], 32'h5A5A5A5A);
        check_eq("t1_wr_data1", wr_data_log[(w0 + 1) % 64], 32'h5A5B5A5B);
        check_eq("t1_wr_data3", wr_data_log[(w0 + 3) % 64], 32'h5A595A59);

        // Word 2 read back with bit 0 flipped
        corrupt = 1'b1;
        repeat (2) @(negedge clk);
        run_once(60);
        check_eq("t2_done_cycles", cycles, 17);
        check_eq("t2_pass", pass, 0);
        check_eq("t2_errcnt", err_count, 1);
        check_eq("t2_erraddr", err_addr, 32'h8);
        check_eq("t2_errdata", err_data, 32'h5A585A59);
        check_eq("t2_timeout", timeout, 0);
        corrupt = 1'b0;

        // Three wait states; start after done must clear previous results
        waits = 3;
        c0 = cyc_cycles; u0 = unstable;
        repeat (2) @(negedge clk);
        run_once(100);
        check_eq("t3_done_cleared", done_n, 0);
        check_eq("t3_errcnt_cleared", errc_n, 0);
        check_eq("t3_done_cycles", cycles, 41);
        check_eq("t3_pass", pass, 1);
        check_eq("t3_errcnt", err_count, 0);
        check_eq("t3_cyc_high", cyc_cycles - c0, 32);
        check_eq("t3_unstable", unstable - u0, 0);
        waits = 0;

        // Slave never acks: abort after TIMEOUT wait cycles
        noack = 1'b1;
        c0 = cyc_cycles; w0 = wr_cnt;
        repeat (2) @(negedge clk);
        run_once(40);
        check_eq("t4_done_cycles", cycles, 10);
        check_eq("t4_cyc_high", cyc_cycles - c0, 8);
        check_eq("t4_timeout", timeout, 1);
        check_eq("t4_done", done, 1);
        check_eq("t4_pass", pass, 0);
        repeat (20) @(negedge clk);
        check_eq("t4_no_more_cyc", cyc_cycles - c0, 8);
        check_eq("t4_no_writes", wr_cnt - w0, 0);
        check_eq("t4_still_done", done, 1);
        noack = 1'b0;

        // Reset asserted during the read pass
        pulse_start();
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (wbm_cyc_o && !wbm_we_o) begin
                found = 1;
                break;
            end
        end
        check_eq("t5_read_seen", found, 1);
        #1 rst = 1'b0;
        #1;
        check_eq("t5_cyc", wbm_cyc_o, 0);
        check_eq("t5_stb", wbm_stb_o, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_once(60);
        check_eq("t5_rerun_cycles", cycles, 17);
        check_eq("t5_rerun_pass", pass, 1);
        check_eq("t5_rerun_errcnt", err_count, 0);

        // Second start edge while busy is ignored
        w0 = wr_cnt; r0 = rd_cnt;
        repeat (2) @(negedge clk);
        pulse_start();
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 1;
        repeat (3) begin
            @(posedge clk);
            cycles++;
        end
        #1 start = 1'b1;
        while (!done && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("t6_done_cycles", cycles, 17);
        check_eq("t6_writes", wr_cnt - w0, 4);
        check_eq("t6_reads", rd_cnt - r0, 4);
        check_eq("t6_pass", pass, 1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_no_restart", busy, 0);
        check_eq("t6_done_held", done, 1);

        // Bus-wide protocol properties over the whole run
        check_eq("stb_eq_cyc", stb_mis, 0);
        check_eq("idle_after_ack", idle_viol, 0);
        check_eq("stable_while_stb", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
